// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: registered N-input bitwise logic unit with an output FIFO.
// NUM_IN operands of WIDTH bits each are combined with a runtime-selected
// bitwise function. The result is pushed into a DEPTH-entry FIFO on the
// accepting edge, so it appears at the head one cycle later.
// Optional feature macro: LOGIC_GATE_PIPE_TXN_COUNT_EN adds a 16-bit
// wrapping count of accepted input transactions on port txn_count.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The input side accepts when in_valid & in_ready. The output side pops
// when out_valid & out_ready. in_ready depends only on rst and the registered
// occupancy, never on out_ready. out_valid and out_data depend only on
// registered state, so they hold steady while the consumer stalls.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [NUM_IN*WIDTH-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] out_count
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
  ,
  output logic [15:0]                txn_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT0 = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_xor;
  logic [WIDTH-1:0] op0;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic push;
  logic pop;

  // Reduce all operands bitwise, then pick the selected function.
  always_comb begin
    op0     = in_data[WIDTH-1:0];
    red_and = op0;
    red_or  = op0;
    red_xor = op0;
    for (int i = 1; i < NUM_IN; i++) begin
      red_and = red_and & in_data[i*WIDTH +: WIDTH];
      red_or  = red_or  | in_data[i*WIDTH +: WIDTH];
      red_xor = red_xor ^ in_data[i*WIDTH +: WIDTH];
    end
    case (op_e'(in_op))
      OP_AND:  result = red_and;
      OP_OR:   result = red_or;
      OP_XOR:  result = red_xor;
      OP_NAND: result = ~red_and;
      OP_NOR:  result = ~red_or;
      OP_XNOR: result = ~red_xor;
      OP_NOT0: result = ~op0;
      OP_PASS: result = op0;
      default: result = op0;
    endcase
  end

  // A full FIFO blocks input even when the consumer pops this same cycle.
  assign in_ready  = !rst && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_count = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; push is already suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= result;
  end

`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
  logic [15:0] txn_count_q, txn_count_d;

  // Accepted-transaction counter, wraps naturally at 16 bits.
  always_comb begin
    txn_count_d = txn_count_q;
    if (push) txn_count_d = txn_count_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) txn_count_q <= '0;
    else     txn_count_q <= txn_count_d;
  end

  assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: three instances cover the default
// configuration, a 1-bit legacy OR build and a 3-operand build.
module tb_logic_gate_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- main instance (8-bit, 2 operands, depth 4) ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [2:0]  out_count;
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
  logic [15:0] txn_count;
`endif

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
    , .txn_count(txn_count)
`endif
  );

  // ---------------- 1-bit instance ----------------
  logic       w1_in_valid = 1'b0;
  logic       w1_in_ready;
  logic [2:0] w1_in_op = 3'd1;
  logic [1:0] w1_in_data = '0;
  logic       w1_out_valid;
  logic       w1_out_ready = 1'b1;
  logic [0:0] w1_out_data;
  logic [2:0] w1_out_count;
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
  logic [15:0] w1_txn_count;
`endif

  logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .DEPTH(4)) dut_w1 (
    .clk(clk), .rst(rst),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_op(w1_in_op), .in_data(w1_in_data),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_data(w1_out_data),
    .out_count(w1_out_count)
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
    , .txn_count(w1_txn_count)
`endif
  );

  // ---------------- 3-operand instance ----------------
  logic        n3_in_valid = 1'b0;
  logic        n3_in_ready;
  logic [2:0]  n3_in_op = 3'd0;
  logic [23:0] n3_in_data = '0;
  logic        n3_out_valid;
  logic        n3_out_ready = 1'b1;
  logic [7:0]  n3_out_data;
  logic [2:0]  n3_out_count;
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
  logic [15:0] n3_txn_count;
`endif

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .DEPTH(4)) dut_n3 (
    .clk(clk), .rst(rst),
    .in_valid(n3_in_valid), .in_ready(n3_in_ready), .in_op(n3_in_op), .in_data(n3_in_data),
    .out_valid(n3_out_valid), .out_ready(n3_out_ready), .out_data(n3_out_data),
    .out_count(n3_out_count)
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
    , .txn_count(n3_txn_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int sent = 0;

  // Stream item k: sent with op 7 (PASS op0), so the expected result is itm(k).
  function automatic logic [7:0] itm(input int k);
    return 8'(k * 37 + 5);
  endfunction

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive PASS items on the main instance for ncyc cycles while sent < max_sent,
  // checking every pop against the expected queue.
  task automatic run_cycles(input int ncyc, input bit rdy, input int max_sent,
                            input int want_count);
    bit acc, pp;
    for (int c = 0; c < ncyc; c++) begin
      in_valid  = (sent < max_sent);
      in_op     = 3'd7;
      in_data   = {~itm(sent), itm(sent)};
      out_ready = rdy;
      @(negedge clk);
      if (want_count >= 0) begin
        checks++;
        if (out_count !== 3'(want_count)) begin
          errors++;
          $display("FAIL stream_count: got %0d want %0d", out_count, want_count);
        end
      end
      if (!out_valid) begin
        checks++;
        if (out_data !== 8'h00) begin
          errors++;
          $display("FAIL idle_data_zero: got %h want 00", out_data);
        end
      end
      pp  = out_valid && out_ready;
      acc = in_valid && in_ready;
      if (pp) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra_pop: got %h want no data", out_data);
        end else if (out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL stream_order: got %h want %h", out_data, exp_q[0]);
        end
      end
      tick();
      if (pp && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(itm(sent));
        sent++;
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || w1_in_ready !== 1'b1 || n3_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_high: got %b%b%b want 111",
                         in_ready, w1_in_ready, n3_in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 3'd0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h c=%0d want v=0 d=00 c=0",
                         out_valid, out_data, out_count);
    end
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
    checks++;
    if (txn_count !== 16'd0) begin
      errors++; $display("FAIL reset_txn: got %0d want 0", txn_count);
    end
`endif
    tick();
  endtask

  task automatic test_legacy_or();
    logic [1:0] ab [4];
    logic       exp [4];
    ab  = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp = '{1'b0, 1'b1, 1'b1, 1'b1};
    w1_out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      w1_in_valid = (k < 4);
      w1_in_op    = 3'd1;
      w1_in_data  = (k < 4) ? ab[k] : 2'b00;
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (w1_out_valid !== 1'b1 || w1_out_data !== exp[k-1]) begin
          errors++; $display("FAIL legacy_or_%0d: got v=%b d=%b want v=1 d=%b",
                             k-1, w1_out_valid, w1_out_data, exp[k-1]);
        end
      end
      tick();
    end
    w1_in_valid = 1'b0;
  endtask

  task automatic test_all_ops();
    logic [7:0] exp [8];
    exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      in_op    = 3'(k);
      in_data  = {8'h3C, 8'hF0};
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp[k-1]) begin
          errors++; $display("FAIL op_%0d: got v=%b d=%h want v=1 d=%h",
                             k-1, out_valid, out_data, exp[k-1]);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    sent = sent + 0;
  endtask

  task automatic test_three_operands();
    logic [2:0] ops [2];
    logic [7:0] exp [2];
    ops = '{3'd2, 3'd0};
    exp = '{8'hF1, 8'h01};
    for (int k = 0; k <= 2; k++) begin
      n3_in_valid = (k < 2);
      n3_in_op    = (k < 2) ? ops[k] : 3'd0;
      n3_in_data  = {8'h01, 8'h0F, 8'hFF};
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (n3_out_valid !== 1'b1 || n3_out_data !== exp[k-1]) begin
          errors++; $display("FAIL three_op_%0d: got v=%b d=%h want v=1 d=%h",
                             k-1, n3_out_valid, n3_out_data, exp[k-1]);
        end
      end
      tick();
    end
    n3_in_valid = 1'b0;
  endtask

  task automatic test_full_backpressure();
    int base;
    exp_q.delete();
    base = sent;
    run_cycles(6, 1'b0, base + 6, -1);
    @(negedge clk);
    checks++;
    if (sent !== base + 4) begin
      errors++; $display("FAIL full_accepted: got %0d want 4", sent - base);
    end
    checks++;
    if (out_count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: got c=%0d r=%b want c=4 r=0", out_count, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== itm(base)) begin
      errors++; $display("FAIL full_head: got %h want %h", out_data, itm(base));
    end
    tick();
    // Consumer pops while full: input must still be blocked this cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 3'd7;
    in_data   = {~itm(sent), itm(sent)};
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_no_comb_ready: got %b want 0", in_ready);
    end
    tick();
    void'(exp_q.pop_front());
    run_cycles(20, 1'b1, base + 6, -1);
    @(negedge clk);
    checks++;
    if (sent !== base + 6 || exp_q.size() != 0 || out_count !== 3'd0) begin
      errors++; $display("FAIL full_drain: got sent=%0d left=%0d c=%0d want 6 0 0",
                         sent - base, exp_q.size(), out_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    run_cycles(2, 1'b0, sent + 2, -1);
    run_cycles(10, 1'b1, sent + 10, 2);
    run_cycles(6, 1'b1, sent, -1);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || out_count !== 3'd0) begin
      errors++; $display("FAIL b2b_drain: got left=%0d c=%0d want 0 0", exp_q.size(), out_count);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    exp_q.delete();
    run_cycles(3, 1'b0, sent + 3, -1);
    @(negedge clk);
    checks++;
    if (out_count !== 3'd3) begin
      errors++; $display("FAIL pre_reset_count: got %0d want 3", out_count);
    end
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_op    = 3'd7;
    in_data  = 16'h5A5A;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ready: got %b want 0", in_ready);
    end
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_state: got v=%b d=%h c=%0d r=%b want 0 00 0 1",
                         out_valid, out_data, out_count, in_ready);
    end
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
    checks++;
    if (txn_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset_txn: got %0d want 0", txn_count);
    end
`endif
    tick();
    run_cycles(1, 1'b1, sent + 1, -1);
`ifdef LOGIC_GATE_PIPE_TXN_COUNT_EN
    @(negedge clk);
    checks++;
    if (txn_count !== 16'd1) begin
      errors++; $display("FAIL txn_after_accept: got %0d want 1", txn_count);
    end
    tick();
`endif
    run_cycles(4, 1'b1, sent, -1);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || out_count !== 3'd0) begin
      errors++; $display("FAIL post_reset_drain: got left=%0d c=%0d want 0 0",
                         exp_q.size(), out_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_legacy_or();
    test_all_ops();
    test_three_operands();
    test_full_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
